fft_digit_rev_b4: RTL

FFT_DIGIT_REV_B4 -- requirements
Module: fft_digit_rev_b4

---
 rtl/fft_digit_rev_b4.sv | 83 ++++++++
 1 files changed

// File: rtl/fft_digit_rev_b4.sv
// Base-4 digit-reversal reorder buffer for a radix-4 FFT output stream.
// Ping-pong banks: one frame is written in reversed order while the previous one is read out naturally.
module fft_digit_rev_b4 #(
    parameter int WORDLENGTH_IO = 16,
    parameter int LOG4N         = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       sof_in,
    input  logic [2*WORDLENGTH_IO-1:0] data_in,
    output logic [2*WORDLENGTH_IO-1:0] data_out,
    output logic                       out_valid,
    output logic                       sof_out,
    output logic                       sync_err
);

    localparam int N  = 4 ** LOG4N;
    localparam int CW = 2 * LOG4N;
    localparam int DW = 2 * WORDLENGTH_IO;

    logic [DW-1:0] mem [2*N];
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] wr_addr;
    logic          wr_bank;
    logic          primed;
    logic          last;
    logic [DW-1:0] rd_data;

    function automatic logic [CW-1:0] drev(input logic [CW-1:0] c);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < LOG4N; i++) begin
            r[2*i +: 2] = c[2*(LOG4N-1-i) +: 2];
        end
        return r;
    endfunction

    // A frame start always lands at address 0, whatever the counter says.
    assign wr_addr = sof_in ? '0 : drev(wr_cnt);
    assign last    = (wr_cnt == CW'(N - 1));
    assign rd_data = mem[{~wr_bank, wr_cnt}];

    always_ff @(posedge clk) begin
        if (enable) begin
            mem[{wr_bank, wr_addr}] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            primed    <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            sof_out   <= 1'b0;
            sync_err  <= 1'b0;
        end else if (!enable) begin
            out_valid <= 1'b0;
            sof_out   <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= primed;
            sof_out   <= primed && (wr_cnt == '0);
            sync_err  <= sof_in && (wr_cnt != '0);
            if (primed) begin
                data_out <= rd_data;
            end
            // Premature start drops the partial frame without swapping banks.
            if (sof_in) begin
                wr_cnt <= CW'(1);
            end else if (last) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
                primed  <= 1'b1;
            end else begin
                wr_cnt <= wr_cnt + CW'(1);
            end
        end
    end

endmodule
